// File: rtl/mem_port_arbiter.sv
// Unified memory bus arbiter between instruction fetch and load/store, with pipeline stall generation.
// Optional ack-wait timeout is enabled by defining MEM_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [3:0]        mem_sel,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    input  logic              id_stall_req,
    input  logic              flush,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_sel,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              bus_err,
    output logic [5:0]        stall
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SERVE_MEM = 2'd1,
        SERVE_IF  = 2'd2,
        DRAIN     = 2'd3
    } state_t;

    state_t              state, state_next;
    logic                bus_req_next, bus_we_next;
    logic [ADDR_W-1:0]   bus_addr_next;
    logic [DATA_W-1:0]   bus_wdata_next;
    logic [3:0]          bus_sel_next;
    logic                if_done_next, mem_done_next, err_next;
    logic [DATA_W-1:0]   if_rdata_next, mem_rdata_next;
    logic                cnt_clr;
    logic                timeout_hit;
    logic                finish;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;

    // Counts un-acked request cycles; fires on the last allowed one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (bus_req && !bus_ack) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign timeout_hit = bus_req && !bus_ack && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^{cnt_clr, 32'(TIMEOUT_CYCLES)};
    assign timeout_hit    = 1'b0;
`endif

    assign finish = bus_ack || timeout_hit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_sel   <= '0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            bus_err   <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            state     <= state_next;
            bus_req   <= bus_req_next;
            bus_we    <= bus_we_next;
            bus_addr  <= bus_addr_next;
            bus_wdata <= bus_wdata_next;
            bus_sel   <= bus_sel_next;
            if_done   <= if_done_next;
            mem_done  <= mem_done_next;
            bus_err   <= err_next;
            if_rdata  <= if_rdata_next;
            mem_rdata <= mem_rdata_next;
        end
    end

    // A requester whose done is currently high is not re-accepted; it drops its request next cycle.
    always_comb begin
        state_next     = state;
        bus_req_next   = bus_req;
        bus_we_next    = bus_we;
        bus_addr_next  = bus_addr;
        bus_wdata_next = bus_wdata;
        bus_sel_next   = bus_sel;
        if_done_next   = 1'b0;
        mem_done_next  = 1'b0;
        err_next       = 1'b0;
        if_rdata_next  = if_rdata;
        mem_rdata_next = mem_rdata;
        cnt_clr        = 1'b0;

        case (state)
            IDLE: begin
                if (mem_req && !mem_done) begin
                    state_next     = SERVE_MEM;
                    bus_req_next   = 1'b1;
                    bus_we_next    = mem_we;
                    bus_addr_next  = mem_addr;
                    bus_wdata_next = mem_wdata;
                    bus_sel_next   = mem_sel;
                    cnt_clr        = 1'b1;
                end else if (if_req && !if_done && !flush) begin
                    state_next    = SERVE_IF;
                    bus_req_next  = 1'b1;
                    bus_we_next   = 1'b0;
                    bus_addr_next = if_addr;
                    bus_sel_next  = 4'hF;
                    cnt_clr       = 1'b1;
                end
            end
            SERVE_MEM: begin
                if (finish) begin
                    state_next     = IDLE;
                    bus_req_next   = 1'b0;
                    mem_done_next  = 1'b1;
                    err_next       = timeout_hit;
                    mem_rdata_next = (bus_we || timeout_hit) ? '0 : bus_rdata;
                end
            end
            SERVE_IF: begin
                if (finish) begin
                    state_next   = IDLE;
                    bus_req_next = 1'b0;
                    if (!flush) begin
                        if_done_next  = 1'b1;
                        err_next      = timeout_hit;
                        if_rdata_next = timeout_hit ? '0 : bus_rdata;
                    end
                end else if (flush) begin
                    state_next = DRAIN;
                    cnt_clr    = 1'b1;
                end
            end
            DRAIN: begin
                if (finish) begin
                    state_next   = IDLE;
                    bus_req_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pipeline stall vector, highest-priority hazard first.
    always_comb begin
        stall = 6'b000000;
        if (!rst) begin
            stall = 6'b000000;
        end else if (mem_req && !mem_done) begin
            stall = 6'b011111;
        end else if (id_stall_req) begin
            stall = 6'b000111;
        end else if ((if_req && !if_done) || (state == DRAIN)) begin
            stall = 6'b000011;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_sel;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        id_stall_req;
    logic        flush;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_sel;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;
    logic [5:0]  stall;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 4;
`else
    localparam int unsigned TB_TIMEOUT = 255;
`endif

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_sel(mem_sel), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .id_stall_req(id_stall_req), .flush(flush),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_sel(bus_sel), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err),
        .stall(stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
        mem_addr = '0; mem_wdata = '0; mem_sel = '0; id_stall_req = 1'b0; flush = 1'b0;
        bus_ack = 1'b0; bus_rdata = '0;
        step(); step();

        // Reset state
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_sel", 32'(bus_sel), 32'd0);
        chk("rst_if_done", 32'(if_done), 32'd0);
        chk("rst_mem_done", 32'(mem_done), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        mem_req = 1'b1; #1;
        chk("rst_stall_masked", 32'(stall), 32'd0);
        mem_req = 1'b0;
        step();
        rst = 1'b1;
        step();

        // Fetch only, ack two cycles after bus_req rises
        if_req = 1'b1; if_addr = 32'h100; #1;
        chk("t1_stall_req", 32'(stall), 32'b000011);
        step();
        chk("t1_bus_req", 32'(bus_req), 32'd1);
        chk("t1_bus_addr", bus_addr, 32'h100);
        chk("t1_bus_we", 32'(bus_we), 32'd0);
        chk("t1_stall_wait", 32'(stall), 32'b000011);
        step();
        chk("t1_bus_req_hold", 32'(bus_req), 32'd1);
        chk("t1_no_done_yet", 32'(if_done), 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'h00A00093;
        step();
        bus_ack = 1'b0; bus_rdata = '0;
        chk("t1_if_done", 32'(if_done), 32'd1);
        chk("t1_if_rdata", if_rdata, 32'h00A00093);
        chk("t1_bus_req_low", 32'(bus_req), 32'd0);
        chk("t1_bus_err", 32'(bus_err), 32'd0);
        chk("t1_stall_done", 32'(stall), 32'd0);
        if_req = 1'b0;
        step();
        chk("t1_single_pulse", 32'(if_done), 32'd0);

        // Simultaneous fetch and load: load wins
        if_req = 1'b1; if_addr = 32'h104;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h2000; mem_sel = 4'hF; #1;
        chk("t2_stall_mem", 32'(stall), 32'b011111);
        step();
        chk("t2_bus_addr_mem", bus_addr, 32'h2000);
        chk("t2_bus_we", 32'(bus_we), 32'd0);
        chk("t2_stall_mem_wait", 32'(stall), 32'b011111);
        bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
        step();
        bus_ack = 1'b0;
        chk("t2_mem_done", 32'(mem_done), 32'd1);
        chk("t2_mem_rdata", mem_rdata, 32'hDEADBEEF);
        chk("t2_if_done_quiet", 32'(if_done), 32'd0);
        chk("t2_stall_if_pending", 32'(stall), 32'b000011);
        mem_req = 1'b0;
        step();
        chk("t2_fetch_bus_req", 32'(bus_req), 32'd1);
        chk("t2_fetch_addr", bus_addr, 32'h104);
        chk("t2_mem_done_pulse", 32'(mem_done), 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'h11111111;
        step();
        bus_ack = 1'b0;
        chk("t2_if_done", 32'(if_done), 32'd1);
        chk("t2_if_rdata", if_rdata, 32'h11111111);
        if_req = 1'b0;
        step();

        // Store: bus carries store fields, completion clears mem_rdata
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h3000; mem_wdata = 32'h1234; mem_sel = 4'b0011;
        step();
        chk("t3_bus_we", 32'(bus_we), 32'd1);
        chk("t3_bus_addr", bus_addr, 32'h3000);
        chk("t3_bus_wdata", bus_wdata, 32'h1234);
        chk("t3_bus_sel", 32'(bus_sel), 32'b0011);
        bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
        step();
        bus_ack = 1'b0;
        chk("t3_mem_done", 32'(mem_done), 32'd1);
        chk("t3_mem_rdata_zero", mem_rdata, 32'd0);
        chk("t3_addr_held", bus_addr, 32'h3000);
        mem_req = 1'b0; mem_we = 1'b0;
        step();

        // Flush one cycle after fetch starts: drain, no if_done
        if_req = 1'b1; if_addr = 32'h180;
        step();
        chk("t4_bus_req", 32'(bus_req), 32'd1);
        flush = 1'b1; if_req = 1'b0;
        step();
        flush = 1'b0;
        chk("t4_drain_stall", 32'(stall), 32'b000011);
        chk("t4_drain_bus_req", 32'(bus_req), 32'd1);
        step();
        chk("t4_drain_stall2", 32'(stall), 32'b000011);
        chk("t4_no_if_done", 32'(if_done), 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'h00000BAD;
        step();
        bus_ack = 1'b0;
        chk("t4_drain_no_done", 32'(if_done), 32'd0);
        chk("t4_drain_bus_req_low", 32'(bus_req), 32'd0);
        chk("t4_rdata_unchanged", if_rdata, 32'h11111111);
        chk("t4_stall_clear", 32'(stall), 32'd0);
        if_req = 1'b1; if_addr = 32'h200;
        step();
        chk("t4_refetch_addr", bus_addr, 32'h200);
        bus_ack = 1'b1; bus_rdata = 32'h00200213;
        step();
        bus_ack = 1'b0;
        chk("t4_refetch_done", 32'(if_done), 32'd1);
        chk("t4_refetch_rdata", if_rdata, 32'h00200213);
        if_req = 1'b0;
        step();

        // Flush in the ack cycle suppresses if_done
        if_req = 1'b1; if_addr = 32'h300;
        step();
        bus_ack = 1'b1; bus_rdata = 32'h55; flush = 1'b1; if_req = 1'b0;
        step();
        bus_ack = 1'b0; flush = 1'b0;
        chk("t5_ackflush_no_done", 32'(if_done), 32'd0);
        chk("t5_ackflush_rdata", if_rdata, 32'h00200213);
        chk("t5_ackflush_bus_req", 32'(bus_req), 32'd0);

        // Load-use stall and its priority under mem_req
        id_stall_req = 1'b1; #1;
        chk("t6_id_stall", 32'(stall), 32'b000111);
        mem_req = 1'b1; #1;
        chk("t6_mem_over_id", 32'(stall), 32'b011111);
        mem_req = 1'b0; id_stall_req = 1'b0;
        step();

        // Reset mid load, late ack ignored
        mem_req = 1'b1; mem_addr = 32'h4000; mem_we = 1'b0;
        step();
        chk("t7_bus_req", 32'(bus_req), 32'd1);
        rst = 1'b0; mem_req = 1'b0; #1;
        chk("t7_stall_rst", 32'(stall), 32'd0);
        step();
        chk("t7_bus_req_cleared", 32'(bus_req), 32'd0);
        chk("t7_no_mem_done", 32'(mem_done), 32'd0);
        rst = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h99999999;
        step();
        bus_ack = 1'b0;
        chk("t7_late_ack_done", 32'(mem_done), 32'd0);
        chk("t7_late_ack_rdata", mem_rdata, 32'd0);
        chk("t7_late_ack_bus_req", 32'(bus_req), 32'd0);
        chk("t7_stall_idle", 32'(stall), 32'd0);
        step();

`ifdef MEM_ARB_TIMEOUT_EN
        // Never-acked fetch times out after TB_TIMEOUT request cycles
        if_req = 1'b1; if_addr = 32'h500;
        step();
        chk("t8_bus_req", 32'(bus_req), 32'd1);
        step(); step(); step();
        chk("t8_still_waiting", 32'(if_done), 32'd0);
        step();
        chk("t8_to_done", 32'(if_done), 32'd1);
        chk("t8_to_err", 32'(bus_err), 32'd1);
        chk("t8_to_rdata", if_rdata, 32'd0);
        chk("t8_to_bus_req", 32'(bus_req), 32'd0);
        if_req = 1'b0;
        step();
        chk("t8_err_pulse", 32'(bus_err), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory bus between instruction fetch (IF) and load/store (MEM).
- Sequences each bus transaction with a small FSM.
- Drives the per-stage pipeline stall vector for memory waits and the ID load-use request.
- Absorbs branch flushes by draining any fetch already in flight.

Parameters:
- ADDR_W, 32, width of address buses.
- DATA_W, 32, width of data buses.
- TIMEOUT_CYCLES, 255, ack-wait limit; used only with MEM_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-low reset (0 = reset).
- if_req  in  1  fetch request; held until if_done.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word; valid when if_done=1.
- if_done  out  1  one-cycle fetch completion pulse.
- mem_req  in  1  load/store request; held until mem_done.
- mem_we  in  1  1 = store.
- mem_addr  in  ADDR_W  load/store address.
- mem_wdata  in  DATA_W  store data.
- mem_sel  in  4  byte enables.
- mem_rdata  out  DATA_W  load data; valid when mem_done=1.
- mem_done  out  1  one-cycle load/store completion pulse.
- id_stall_req  in  1  load-use hazard from ID.
- flush  in  1  branch taken in EX; kills the younger fetch.
- bus_req, bus_we, bus_addr, bus_wdata, bus_sel  out  1/1/ADDR_W/DATA_W/4  memory bus request; all registered.
- bus_ack  in  1  one-cycle ack; bus_rdata is valid in the same cycle.
- bus_rdata  in  DATA_W  read data.
- bus_err  out  1  timeout pulse, aligned with done.
- stall  out  6  [0]=pc, [1]=if, [2]=id, [3]=ex, [4]=mem, [5]=wb.

Behaviour:
- Reset (rst=0 at a clock edge), all outputs: state IDLE; bus_req, bus_we, bus_addr, bus_wdata, bus_sel = 0; if_done, mem_done, bus_err = 0; if_rdata, mem_rdata = 0.
- Reset mid-transaction aborts it. No done pulse is issued, and a late bus_ack is ignored.
- FSM states: IDLE, SERVE_MEM, SERVE_IF, DRAIN.
- IDLE:
  - mem_req=1 -> SERVE_MEM. MEM has priority over IF.
  - else if_req=1 and flush=0 -> SERVE_IF.
  - bus_* are loaded from the chosen requester on the same edge, so bus_req rises 1 cycle after the request is sampled.
- SERVE_MEM / SERVE_IF:
  - Hold bus_req and all bus_* stable until bus_ack.
  - On the ack edge: bus_req <= 0, rdata latched, the matching done pulses 1 cycle, -> IDLE.
  - Minimum request-to-done latency is 2 cycles (ack in the first bus_req cycle).
  - A new transaction may start in the cycle after done.
- Stores: on completion, mem_rdata is set to 0.
- flush=1 while in SERVE_IF -> DRAIN. bus_req stays high until ack, then -> IDLE with no if_done and if_rdata unchanged.
- flush=1 in the ack cycle of SERVE_IF also suppresses if_done.
- flush has no effect on SERVE_MEM.
- Done pulses are registered and never assert in the same cycle as each other.
- stall (combinational, priority order):
  - mem_req=1 and mem_done=0 -> 6'b011111.
  - else id_stall_req=1 -> 6'b000111.
  - else if_req=1 and if_done=0, or state=DRAIN -> 6'b000011.
  - else 6'b000000.
  - During reset, stall is 6'b000000.
- bus_addr, bus_wdata and bus_sel keep their last values when bus_req=0. bus_we is 0 for fetches.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entering SERVE_*/DRAIN and increments each cycle bus_req=1 with bus_ack=0.
  - When the count reaches TIMEOUT_CYCLES, the FSM forces completion: bus_req <= 0, rdata = 0, done pulses with bus_err=1 for 1 cycle (no done in DRAIN), -> IDLE.
- Not defined: no counter, the FSM waits indefinitely, and bus_err is tied to 0.

Test Plan:
- IF only, if_addr=0x100, ack 2 cycles after bus_req rises with bus_rdata=0x00A00093 -> bus_addr=0x100, bus_we=0; stall=000011 until if_done; single if_done pulse with if_rdata=0x00A00093.
- if_req (0x104) and mem_req load (0x2000) in the same cycle -> bus_addr=0x2000 first with stall=011111; mem_done, then the fetch of 0x104 starts the next cycle.
- Store mem_we=1, mem_addr=0x3000, mem_wdata=0x1234, mem_sel=4'b0011 -> bus_we=1 with those values; mem_done with mem_rdata=0.
- flush one cycle after SERVE_IF entry, ack 3 cycles later -> state DRAIN, no if_done, stall=000011 until ack; next fetch of 0x200 completes normally.
- rst=0 mid SERVE_MEM, ack arrives after reset -> bus_req=0 next cycle, no mem_done, stall=000000.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, never ack a fetch -> if_done with bus_err=1 and if_rdata=0 after 4 bus_req cycles.
